// File: rtl/pulse_meter_if.sv
// rtl/pulse_meter_if.sv - result/acknowledge bundle between pulse_meter and its consumer
interface pulse_meter_if #(
    parameter int W = 8
);
    logic         get;
    logic         ready;
    logic [W-1:0] width;
    logic [W-1:0] period;
    logic         over;
    logic         miss;

    modport master (
        output ready, width, period, over, miss,
        input  get
    );

    modport slave (
        input  ready, width, period, over, miss,
        output get
    );
endinterface

// File: rtl/pulse_meter.sv
// rtl/pulse_meter.sv - high-width and rise-to-rise period capture of a 1-bit input
// Optional PULSE_METER_SYNC_EN: 2-flop synchronizer in front of edge detect.
module pulse_meter #(
    parameter int W = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            sense,
    pulse_meter_if.master   bus
);
    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = W'(1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t       state_q;
    logic         s_prev_q;
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] w_tmp_q;
    logic         w_sat_q;
    logic [W-1:0] width_q;
    logic [W-1:0] period_q;
    logic         ready_q;
    logic         over_q;
    logic         miss_q;

    logic s;
    logic rise;
    logic fall;
    logic sat;

`ifdef PULSE_METER_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sense;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = sense;
`endif

    // s_prev resets low, so an input already high out of reset counts as a rise.
    assign rise = s & ~s_prev_q;
    assign fall = ~s & s_prev_q;
    assign sat  = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = CNT_ONE;
        end else if (!sat) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            s_prev_q <= 1'b0;
            cnt_q    <= '0;
            w_tmp_q  <= '0;
            w_sat_q  <= 1'b0;
            width_q  <= '0;
            period_q <= '0;
            ready_q  <= 1'b0;
            over_q   <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            s_prev_q <= s;
            cnt_q    <= cnt_d;
            if (bus.get) begin
                ready_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        w_tmp_q <= cnt_q;
                        w_sat_q <= sat;
                        state_q <= LOW;
                    end
                end
                LOW: begin
                    // A completed period overrides a same-cycle acknowledge of the old result.
                    if (rise) begin
                        width_q  <= w_tmp_q;
                        period_q <= cnt_q;
                        over_q   <= w_sat_q | sat;
                        ready_q  <= 1'b1;
                        miss_q   <= miss_q | (ready_q & ~bus.get);
                        state_q  <= HIGH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready  = ready_q;
    assign bus.width  = width_q;
    assign bus.period = period_q;
    assign bus.over   = over_q;
    assign bus.miss   = miss_q;
endmodule

// File: tb/tb_pulse_meter.sv
// tb/tb_pulse_meter.sv - scoreboard bench for pulse_meter (directed sense waveforms)
module tb_pulse_meter;
    localparam int W = 8;
`ifdef PULSE_METER_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [W-1:0] width;
        logic [W-1:0] period;
        logic         over;
        logic         miss;
    } res_t;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic sense = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   lat_n;
    res_t exp_q[$];
    res_t mon_act;
    res_t mon_exp;

    always #5 clock = ~clock;

    pulse_meter_if #(.W(W)) bus ();

    pulse_meter #(.W(W)) dut (
        .clock (clock),
        .reset (resetn),
        .sense (sense),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Each accepted result (ready & get at the sampling edge) is checked against the queue head.
    always @(negedge clock) begin
        if (resetn && bus.ready && bus.get) begin
            mon_act = '{width: bus.width, period: bus.period, over: bus.over, miss: bus.miss};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got w=%0d p=%0d over=%0d miss=%0d, none expected",
                         mon_act.width, mon_act.period, mon_act.over, mon_act.miss);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL result: got w=%0d p=%0d over=%0d miss=%0d expected w=%0d p=%0d over=%0d miss=%0d",
                             mon_act.width, mon_act.period, mon_act.over, mon_act.miss,
                             mon_exp.width, mon_exp.period, mon_exp.over, mon_exp.miss);
                end
            end
        end
    end

    task automatic seg(input logic lvl, input int n);
        sense = lvl;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push(input int w, input int p, input logic ov, input logic ms);
        exp_q.push_back('{width: W'(w), period: W'(p), over: ov, miss: ms});
    endtask

    task automatic do_reset(input logic lvl);
        chk("sb_empty_before_reset", exp_q.size(), 0);
        resetn  = 1'b0;
        sense   = lvl;
        bus.get = 1'b0;
        repeat (5) begin
            @(posedge clock);
            #1;
        end
        chk("rst_ready", bus.ready, 0);
        chk("rst_width", bus.width, 0);
        chk("rst_period", bus.period, 0);
        chk("rst_over", bus.over, 0);
        chk("rst_miss", bus.miss, 0);
        resetn = 1'b1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.ready && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        bus.get = 1'b1;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
        bus.get = 1'b0;
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        bus.get = 1'b0;

        // 1: high 3 / low 7; result on the second rise, get pulse clears ready
        do_reset(1'b0);
        seg(1'b0, 2);
        seg(1'b1, 3);
        seg(1'b0, 7);
        chk("s1_no_result_yet", bus.ready, 0);
        push(3, 10, 1'b0, 1'b0);
        sense = 1'b1;
        wait_ready(lat_n);
        chk("s1_latency", lat_n, LAT);
        @(posedge clock);
        #1 bus.get = 1'b1;
        @(posedge clock);
        #1 bus.get = 1'b0;
        chk("s1_get_clears_ready", bus.ready, 0);
        chk("s1_consumed", exp_q.size(), 0);
        seg(1'b0, 3);

        // 2: 1 high / 1 low with get held -> width 1, period 2, never miss
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) push(1, 2, 1'b0, 1'b0);
        bus.get = 1'b1;
        seg(1'b0, 2);
        for (int i = 0; i < 6; i++) begin
            seg(1'b1, 1);
            seg(1'b0, 1);
        end
        seg(1'b0, 4);
        bus.get = 1'b0;
        chk("s2_all_results", exp_q.size(), 0);

        // 3: stuck high saturates both counters, then a normal period clears over
        do_reset(1'b0);
        push(255, 255, 1'b1, 1'b0);
        push(4, 8, 1'b0, 1'b0);
        bus.get = 1'b1;
        seg(1'b0, 2);
        seg(1'b1, 300);
        seg(1'b0, 5);
        seg(1'b1, 4);
        seg(1'b0, 4);
        seg(1'b1, 1);
        seg(1'b0, 4);
        bus.get = 1'b0;
        chk("s3_all_results", exp_q.size(), 0);

        // 4a: two unread results -> second one shown with miss set
        do_reset(1'b0);
        push(2, 6, 1'b0, 1'b1);
        seg(1'b0, 2);
        seg(1'b1, 2);
        seg(1'b0, 3);
        seg(1'b1, 2);
        seg(1'b0, 4);
        seg(1'b1, 1);
        seg(1'b0, 3);
        chk("s4_miss_set", bus.miss, 1);
        drain("s4a_drain");

        // 4b: get on the very edge a new result loads -> ready stays, no miss
        do_reset(1'b0);
        push(2, 5, 1'b0, 1'b0);
        push(2, 6, 1'b0, 1'b0);
        seg(1'b0, 2);
        seg(1'b1, 2);
        seg(1'b0, 3);
        seg(1'b1, 2);
        seg(1'b0, 4);
        sense = 1'b1;
        repeat (LAT - 1) begin
            @(posedge clock);
            #1;
        end
        bus.get = 1'b1;
        @(posedge clock);
        #1 bus.get = 1'b0;
        chk("s4b_ready_stays", bus.ready, 1);
        chk("s4b_no_miss", bus.miss, 0);
        seg(1'b1, 2);
        drain("s4b_drain");

        // 5: reset in mid-HIGH; a high input out of reset only arms
        do_reset(1'b0);
        seg(1'b0, 2);
        seg(1'b1, 2);
        do_reset(1'b1);
        push(3, 7, 1'b0, 1'b0);
        seg(1'b1, 3);
        seg(1'b0, 4);
        chk("s5_no_early_result", bus.ready, 0);
        sense = 1'b1;
        wait_ready(lat_n);
        chk("s5_latency", lat_n, LAT);
        drain("s5_drain");
        seg(1'b0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
